regfile_read_port: RTL and testbench

//  Dual-operand read side of the 32x64 ARM register file; the file's write side exposes all register contents plus a one-hot write enable.

---
 rtl/regfile_pkg.sv | 25 ++
 rtl/regfile_read_mux.sv | 39 +++
 rtl/regfile_read_port.sv | 103 ++++++++++
 tb/tb_regfile_read_port.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and sizes for the ARM register file read side.
// The top and the operand select mux import this package.
package regfile_pkg;

    localparam int NREGS   = 32;
    localparam int WIDTH   = 64;
    localparam int AW      = 5;
    localparam int XZR_IDX = 31;

    typedef logic [AW-1:0]    reg_addr_t;
    typedef logic [WIDTH-1:0] reg_word_t;

    typedef struct packed {
        reg_word_t rn;
        reg_word_t rm;
    } operand_pair_t;

    function automatic operand_pair_t make_pair(input reg_word_t rn, input reg_word_t rm);
        operand_pair_t p;
        p.rn = rn;
        p.rm = rm;
        return p;
    endfunction

endpackage

// File: rtl/regfile_read_mux.sv
// Combinational select of one read operand.
// Priority: zero register, then same-edge write bypass, then the array contents.
module regfile_read_mux
    import regfile_pkg::*;
#(
    parameter int NREGS    = regfile_pkg::NREGS,
    parameter int WIDTH    = regfile_pkg::WIDTH,
    parameter int AW       = regfile_pkg::AW,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic [AW-1:0]               addr,
    input  logic [NREGS-1:0][WIDTH-1:0] regs_in,
    input  logic [NREGS-1:0]            wr_en,
    input  logic [WIDTH-1:0]            wr_data,
    output logic [WIDTH-1:0]            data
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);
    localparam logic [AW:0]   NREGS_W  = (AW+1)'(NREGS);

    logic in_range;
    logic is_zero;

    // Addresses beyond NREGS only exist when NREGS is not a power of two.
    assign in_range = ({1'b0, addr} < NREGS_W);
    assign is_zero  = ZERO_REG && (addr == LAST_IDX);

    always_comb begin
        data = '0;
        if (is_zero || !in_range) begin
            data = '0;
        end else if (wr_en[addr]) begin
            data = wr_data;
        end else begin
            data = regs_in[addr];
        end
    end

endmodule

// File: rtl/regfile_read_port.sv
// Dual-operand read port: selects Rn/Rm at acceptance and delivers the pair
// through a registered valid/ready output backed by a one-entry skid buffer.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int NREGS    = regfile_pkg::NREGS,
    parameter int WIDTH    = regfile_pkg::WIDTH,
    parameter int AW       = regfile_pkg::AW,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NREGS-1:0][WIDTH-1:0] regs_in,
    input  logic [NREGS-1:0]            wr_en,
    input  logic [WIDTH-1:0]            wr_data,
    input  logic                        rd_req,
    output logic                        rd_ready,
    input  logic [AW-1:0]               rn_addr,
    input  logic [AW-1:0]               rm_addr,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            rn_data,
    output logic [WIDTH-1:0]            rm_data
);

    // Handshakes: a request transfers when rd_req && rd_ready at posedge; a pair
    // transfers to the consumer when out_valid && out_ready at posedge. Once
    // raised, out_valid holds with stable data until that transfer happens.

    logic [WIDTH-1:0] rn_sel;
    logic [WIDTH-1:0] rm_sel;
    operand_pair_t    sel_pair;
    operand_pair_t    out_q;
    operand_pair_t    skid_q;
    logic             out_valid_q;
    logic             skid_full_q;
    logic             accept;
    logic             deliver;

    regfile_read_mux #(
        .NREGS   (NREGS),
        .WIDTH   (WIDTH),
        .AW      (AW),
        .ZERO_REG(ZERO_REG)
    ) u_rn_mux (
        .addr   (rn_addr),
        .regs_in(regs_in),
        .wr_en  (wr_en),
        .wr_data(wr_data),
        .data   (rn_sel)
    );

    regfile_read_mux #(
        .NREGS   (NREGS),
        .WIDTH   (WIDTH),
        .AW      (AW),
        .ZERO_REG(ZERO_REG)
    ) u_rm_mux (
        .addr   (rm_addr),
        .regs_in(regs_in),
        .wr_en  (wr_en),
        .wr_data(wr_data),
        .data   (rm_sel)
    );

    assign sel_pair = make_pair(rn_sel, rm_sel);
    assign accept   = rd_req && rd_ready;
    assign deliver  = out_valid_q && out_ready;

    // Pairs are snapshots taken at acceptance; nothing rewrites them while they wait.
    // Accept and deliver with the skid full cannot coincide because rd_ready is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            skid_full_q <= 1'b0;
            out_q       <= '0;
            skid_q      <= '0;
        end else if (deliver) begin
            if (skid_full_q) begin
                out_q       <= skid_q;
                skid_full_q <= 1'b0;
            end else if (accept) begin
                out_q <= sel_pair;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (accept) begin
            if (!out_valid_q) begin
                out_q       <= sel_pair;
                out_valid_q <= 1'b1;
            end else begin
                skid_q      <= sel_pair;
                skid_full_q <= 1'b1;
            end
        end
    end

    assign rd_ready  = !skid_full_q;
    assign out_valid = out_valid_q;
    assign rn_data   = out_q.rn;
    assign rm_data   = out_q.rm;

endmodule

// File: tb/tb_regfile_read_port.sv
// Bench for regfile_read_port: directed vectors plus a random phase, checked by a
// scoreboard queue that the output monitor drains on every delivered pair.
module tb_regfile_read_port;

    logic                clk;
    logic                reset;
    logic [31:0][63:0]   regs_in;
    logic [31:0]         wr_en;
    logic [63:0]         wr_data;
    logic                rd_req;
    logic [4:0]          rn_addr;
    logic [4:0]          rm_addr;
    logic                out_ready;

    logic                rd_ready;
    logic                out_valid;
    logic [63:0]         rn_data;
    logic [63:0]         rm_data;
    logic                rd_ready0;
    logic                out_valid0;
    logic [63:0]         rn_data0;
    logic [63:0]         rm_data0;

    logic [127:0] exp_q[$];
    logic [127:0] exp0_q[$];
    int           n_checks;
    int           n_fail;
    int           accept_cnt;
    bit           after_reset;
    bit           model_ready;
    bit           model_valid;
    logic [127:0] got;
    logic [127:0] want;

    regfile_read_port #(.ZERO_REG(1'b1)) dut (
        .clk(clk), .reset(reset), .regs_in(regs_in), .wr_en(wr_en), .wr_data(wr_data),
        .rd_req(rd_req), .rd_ready(rd_ready), .rn_addr(rn_addr), .rm_addr(rm_addr),
        .out_valid(out_valid), .out_ready(out_ready), .rn_data(rn_data), .rm_data(rm_data)
    );

    regfile_read_port #(.ZERO_REG(1'b0)) dut0 (
        .clk(clk), .reset(reset), .regs_in(regs_in), .wr_en(wr_en), .wr_data(wr_data),
        .rd_req(rd_req), .rd_ready(rd_ready0), .rn_addr(rn_addr), .rm_addr(rm_addr),
        .out_valid(out_valid0), .out_ready(out_ready), .rn_data(rn_data0), .rm_data(rm_data0)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model_sel(input logic [4:0] a, input bit zr);
        if (zr && a == 5'd31) return 64'd0;
        if (wr_en[a]) return wr_data;
        return regs_in[a];
    endfunction

    // Monitor / scoreboard: inputs change just after posedge, so at negedge they
    // show exactly what the next posedge will sample.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            exp0_q.delete();
            after_reset = 1'b1;
        end else begin
            if (after_reset) begin
                check("reset_data", {rn_data, rm_data}, 128'd0);
                check("reset_data_zr0", {rn_data0, rm_data0}, 128'd0);
                after_reset = 1'b0;
            end
            model_ready = (exp_q.size() < 2);
            model_valid = (exp_q.size() != 0);
            check("rd_ready", {127'd0, rd_ready}, {127'd0, model_ready});
            check("out_valid", {127'd0, out_valid}, {127'd0, model_valid});
            check("rd_ready_zr0", {127'd0, rd_ready0}, {127'd0, exp0_q.size() < 2});
            check("out_valid_zr0", {127'd0, out_valid0}, {127'd0, exp0_q.size() != 0});
            if (model_valid && out_ready) begin
                want = exp_q.pop_front();
                check("pair", {rn_data, rm_data}, want);
                want = exp0_q.pop_front();
                check("pair_zr0", {rn_data0, rm_data0}, want);
            end
            if (rd_req && model_ready) begin
                exp_q.push_back({model_sel(rn_addr, 1'b1), model_sel(rm_addr, 1'b1)});
                exp0_q.push_back({model_sel(rn_addr, 1'b0), model_sel(rm_addr, 1'b0)});
                accept_cnt++;
            end
        end
    end

    // Driver tasks
    task automatic idle(input int n);
        rd_req = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rn, input logic [4:0] rm);
        int start;
        start   = accept_cnt;
        rd_req  = 1'b1;
        rn_addr = rn;
        rm_addr = rm;
        for (int i = 0; i < 50 && accept_cnt == start; i++) begin
            @(posedge clk);
            #1;
        end
        if (accept_cnt == start) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout: got no accept for rn=%0d rm=%0d expected accept within 50 cycles", rn, rm);
        end
        rd_req = 1'b0;
    endtask

    initial begin
        int start;
        n_checks = 0; n_fail = 0; accept_cnt = 0; after_reset = 1'b0;
        reset = 1'b1; rd_req = 1'b0; out_ready = 1'b1;
        wr_en = '0; wr_data = '0; regs_in = '0; rn_addr = '0; rm_addr = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        idle(1);

        // Basic read: expect 15 / 20
        regs_in[1] = 64'd15; regs_in[2] = 64'd20;
        issue(5'd1, 5'd2);
        idle(2);

        // XZR with a write to X31: 0/0 on ZERO_REG=1, bypass 35 on ZERO_REG=0
        wr_en = 32'h8000_0000; wr_data = 64'd35;
        issue(5'd31, 5'd31);
        wr_en = '0;
        regs_in[31] = 64'd99;
        issue(5'd31, 5'd31);
        idle(2);

        // Bypass: X5 written with 28 this cycle, X6 from the array (7)
        regs_in[5] = 64'd40; regs_in[6] = 64'd7;
        wr_en = 32'h20; wr_data = 64'd28;
        issue(5'd5, 5'd6);
        wr_en = '0;
        // Two write enables at once: both bypass
        wr_en = 32'h0000_0300; wr_data = 64'hDEAD_BEEF_0000_1111;
        issue(5'd8, 5'd9);
        wr_en = '0;
        idle(2);

        // Backpressure: A into OUT, B into SKID, then writes to X1 while A waits
        out_ready = 1'b0;
        regs_in[3] = 64'd33; regs_in[4] = 64'd44;
        issue(5'd1, 5'd2);
        issue(5'd3, 5'd4);
        regs_in[1] = 64'd111; wr_en = 32'h2; wr_data = 64'd77;
        regs_in[7] = 64'd70; regs_in[8] = 64'd80;
        rd_req = 1'b1; rn_addr = 5'd7; rm_addr = 5'd8;
        repeat (3) @(posedge clk);
        #1 wr_en = '0;
        start = accept_cnt;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && accept_cnt == start; i++) begin
            @(posedge clk);
            #1;
        end
        check("held_req_accepted", {96'd0, 32'(accept_cnt - start)}, 128'd1);
        idle(4);

        // Reset with OUT and SKID both full
        out_ready = 1'b0;
        issue(5'd3, 5'd4);
        issue(5'd5, 5'd6);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        idle(4);

        // Random phase; a refused request is held until accepted
        for (int c = 0; c < 400; c++) begin
            if (!(rd_req && accept_cnt == start)) begin
                rd_req  = ($urandom_range(0, 1) == 1);
                rn_addr = 5'($urandom_range(0, 31));
                rm_addr = 5'($urandom_range(0, 31));
            end
            start     = accept_cnt;
            out_ready = ($urandom_range(0, 3) != 0);
            wr_data   = {$urandom, $urandom};
            wr_en     = '0;
            if ($urandom_range(0, 2) == 0) wr_en[$urandom_range(0, 31)] = 1'b1;
            if ($urandom_range(0, 5) == 0) wr_en[$urandom_range(0, 31)] = 1'b1;
            regs_in[$urandom_range(0, 31)] = {$urandom, $urandom};
            @(posedge clk);
            #1;
        end

        rd_req = 1'b0; out_ready = 1'b1; wr_en = '0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("drained", {96'd0, 32'(exp_q.size())}, 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
